// File: rtl/brch_resolve_ctrl_if.sv
// Handshake bundle between decode/execute/fetch control and the branch resolution controller.
// The master side drives branch and flag information; the slave side is the controller.
interface brch_resolve_ctrl_if #(
    parameter int PC_W  = 16,
    parameter int CNT_W = 16
);
    logic              br_valid;
    logic [2:0]        br_instr;
    logic [PC_W-1:0]   br_target;
    logic              br_ready;
    logic              flags_valid;
    logic              SF;
    logic              ZF;
    logic              ext_flush;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic              flush;
    logic              timeout_err;
    logic [CNT_W-1:0]  br_cnt;
    logic [CNT_W-1:0]  taken_cnt;

    modport master (
        output br_valid, br_instr, br_target, flags_valid, SF, ZF, ext_flush,
        input  br_ready, redirect, redirect_pc, flush, timeout_err, br_cnt, taken_cnt
    );

    modport slave (
        input  br_valid, br_instr, br_target, flags_valid, SF, ZF, ext_flush,
        output br_ready, redirect, redirect_pc, flush, timeout_err, br_cnt, taken_cnt
    );
endinterface

// File: rtl/brch_resolve_ctrl.sv
// Branch resolution sequencer: holds one outstanding branch until execute supplies flags,
// then redirects fetch and squashes younger stages for FLUSH_CYCLES when the branch is taken.
module brch_resolve_ctrl #(
    parameter int PC_W         = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_WAIT     = 8,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic rst_n,
    brch_resolve_ctrl_if.slave bus
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int FL_W   = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, WAIT_FLAGS, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [2:0]        instr_q, instr_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [FL_W-1:0]   fl_q, fl_d;
    logic              ready_q, ready_d;
    logic              redirect_q, redirect_d;
    logic              flush_q, flush_d;
    logic              tmo_q, tmo_d;
    logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;
    logic              cond;

    always_comb begin
        cond = 1'b0;
        case (instr_q[1:0])
            2'b00:   cond = bus.ZF;
            2'b01:   cond = ~bus.ZF;
            2'b10:   cond = bus.SF;
            default: cond = ~bus.SF;
        endcase
        cond = cond & instr_q[2];
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        wait_d      = wait_q;
        fl_d        = fl_q;
        ready_d     = ready_q;
        redirect_d  = 1'b0;
        flush_d     = flush_q;
        tmo_d       = tmo_q;
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.br_valid) begin
                    state_d = WAIT_FLAGS;
                    instr_d = bus.br_instr;
                    pc_d    = bus.br_target;
                    wait_d  = '0;
                    ready_d = 1'b0;
                end
            end
            WAIT_FLAGS: begin
                if (bus.flags_valid) begin
                    br_cnt_d = (br_cnt_q == '1) ? br_cnt_q : br_cnt_q + 1'b1;
                    if (cond) begin
                        taken_cnt_d = (taken_cnt_q == '1) ? taken_cnt_q : taken_cnt_q + 1'b1;
                        state_d     = FLUSH;
                        redirect_d  = 1'b1;
                        flush_d     = 1'b1;
                        fl_d        = FL_W'(FLUSH_CYCLES - 1);
                    end else begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                    end
                end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
                    // wait_q lags the cycle count by one, so this is the MAX_WAIT-th waiting cycle
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            FLUSH: begin
                if (fl_q == '0) begin
                    state_d = IDLE;
                    flush_d = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    fl_d = fl_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                flush_d = 1'b0;
                ready_d = 1'b1;
            end
        endcase

        // An abort discards whatever the pending branch would have done this cycle.
        if (bus.ext_flush) begin
            state_d     = IDLE;
            instr_d     = instr_q;
            pc_d        = pc_q;
            ready_d     = 1'b1;
            redirect_d  = 1'b0;
            flush_d     = 1'b0;
            tmo_d       = tmo_q;
            br_cnt_d    = br_cnt_q;
            taken_cnt_d = taken_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            instr_q     <= '0;
            pc_q        <= '0;
            wait_q      <= '0;
            fl_q        <= '0;
            ready_q     <= 1'b1;
            redirect_q  <= 1'b0;
            flush_q     <= 1'b0;
            tmo_q       <= 1'b0;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            wait_q      <= wait_d;
            fl_q        <= fl_d;
            ready_q     <= ready_d;
            redirect_q  <= redirect_d;
            flush_q     <= flush_d;
            tmo_q       <= tmo_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign bus.br_ready    = ready_q;
    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = pc_q;
    assign bus.flush       = flush_q;
    assign bus.timeout_err = tmo_q;
    assign bus.br_cnt      = br_cnt_q;
    assign bus.taken_cnt   = taken_cnt_q;
endmodule

// File: tb/tb_brch_resolve_ctrl.sv
// Directed bench for brch_resolve_ctrl; narrow statistics counters make saturation reachable.
module tb_brch_resolve_ctrl;
    localparam int PC_W  = 16;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    int exp_br = 0;
    int exp_tk = 0;

    always #5 clk = ~clk;

    brch_resolve_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    brch_resolve_ctrl #(.PC_W(PC_W), .FLUSH_CYCLES(2), .MAX_WAIT(8), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.br_valid    = 1'b0;
        bus.br_instr    = 3'b000;
        bus.br_target   = '0;
        bus.flags_valid = 1'b0;
        bus.SF          = 1'b0;
        bus.ZF          = 1'b0;
        bus.ext_flush   = 1'b0;
    endtask

    task automatic accept(input logic [2:0] instr, input logic [PC_W-1:0] tgt);
        bus.br_valid  = 1'b1;
        bus.br_instr  = instr;
        bus.br_target = tgt;
        step();
        bus.br_valid  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step(); step();
        tests++; if (bus.br_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", bus.br_ready); end
        tests++; if (bus.redirect !== 1'b0) begin fails++; $display("FAIL reset_redirect got %b want 0", bus.redirect); end
        tests++; if (bus.redirect_pc !== 16'h0000) begin fails++; $display("FAIL reset_pc got %h want 0000", bus.redirect_pc); end
        tests++; if (bus.flush !== 1'b0) begin fails++; $display("FAIL reset_flush got %b want 0", bus.flush); end
        tests++; if (bus.timeout_err !== 1'b0) begin fails++; $display("FAIL reset_tmo got %b want 0", bus.timeout_err); end
        tests++; if (bus.br_cnt !== 4'd0 || bus.taken_cnt !== 4'd0) begin fails++; $display("FAIL reset_cnt got %0d/%0d want 0/0", bus.br_cnt, bus.taken_cnt); end
        rst_n = 1'b1;
        step();
        $display("[TB] reset done");
    endtask

    task automatic test_beqz_taken();
        accept(3'b100, 16'h1234);
        tests++; if (bus.br_ready !== 1'b0) begin fails++; $display("FAIL beqz_busy got %b want 0", bus.br_ready); end
        step();
        tests++; if (bus.redirect !== 1'b0 || bus.flush !== 1'b0) begin fails++; $display("FAIL beqz_early got r=%b f=%b want 0/0", bus.redirect, bus.flush); end
        bus.flags_valid = 1'b1; bus.ZF = 1'b1;
        step();
        bus.flags_valid = 1'b0; bus.ZF = 1'b0;
        exp_br++; exp_tk++;
        tests++; if (bus.redirect !== 1'b1) begin fails++; $display("FAIL beqz_redirect got %b want 1", bus.redirect); end
        tests++; if (bus.redirect_pc !== 16'h1234) begin fails++; $display("FAIL beqz_pc got %h want 1234", bus.redirect_pc); end
        tests++; if (bus.flush !== 1'b1) begin fails++; $display("FAIL beqz_flush1 got %b want 1", bus.flush); end
        tests++; if (bus.br_cnt !== 4'(exp_br) || bus.taken_cnt !== 4'(exp_tk)) begin fails++; $display("FAIL beqz_cnt got %0d/%0d want %0d/%0d", bus.br_cnt, bus.taken_cnt, exp_br, exp_tk); end
        step();
        tests++; if (bus.redirect !== 1'b0 || bus.flush !== 1'b1 || bus.br_ready !== 1'b0) begin fails++; $display("FAIL beqz_flush2 got r=%b f=%b rdy=%b want 0/1/0", bus.redirect, bus.flush, bus.br_ready); end
        step();
        tests++; if (bus.flush !== 1'b0 || bus.br_ready !== 1'b1) begin fails++; $display("FAIL beqz_end got f=%b rdy=%b want 0/1", bus.flush, bus.br_ready); end
        $display("[TB] beqz taken transaction done");
    endtask

    task automatic test_bltz_not_taken();
        accept(3'b110, 16'h0ABC);
        bus.flags_valid = 1'b1; bus.SF = 1'b0; bus.ZF = 1'b1;
        step();
        idle_inputs();
        exp_br++;
        tests++; if (bus.redirect !== 1'b0 || bus.flush !== 1'b0 || bus.br_ready !== 1'b1) begin fails++; $display("FAIL bltz_nt got r=%b f=%b rdy=%b want 0/0/1", bus.redirect, bus.flush, bus.br_ready); end
        tests++; if (bus.br_cnt !== 4'(exp_br) || bus.taken_cnt !== 4'(exp_tk)) begin fails++; $display("FAIL bltz_cnt got %0d/%0d want %0d/%0d", bus.br_cnt, bus.taken_cnt, exp_br, exp_tk); end
        $display("[TB] bltz not-taken transaction done");
    endtask

    task automatic test_disabled_and_hold();
        accept(3'b011, 16'h2222);
        bus.br_valid = 1'b1; bus.br_instr = 3'b100; bus.br_target = 16'h3333;
        step();
        tests++; if (bus.br_ready !== 1'b0 || bus.redirect_pc !== 16'h2222) begin fails++; $display("FAIL hold_ignored got rdy=%b pc=%h want 0/2222", bus.br_ready, bus.redirect_pc); end
        bus.br_valid = 1'b0;
        bus.flags_valid = 1'b1; bus.ZF = 1'b0; bus.SF = 1'b0;
        step();
        idle_inputs();
        exp_br++;
        tests++; if (bus.redirect !== 1'b0 || bus.flush !== 1'b0 || bus.br_ready !== 1'b1) begin fails++; $display("FAIL disabled_nt got r=%b f=%b rdy=%b want 0/0/1", bus.redirect, bus.flush, bus.br_ready); end
        tests++; if (bus.br_cnt !== 4'(exp_br) || bus.taken_cnt !== 4'(exp_tk)) begin fails++; $display("FAIL disabled_cnt got %0d/%0d want %0d/%0d", bus.br_cnt, bus.taken_cnt, exp_br, exp_tk); end
        $display("[TB] disabled branch transaction done");
    endtask

    task automatic test_timeout();
        accept(3'b100, 16'h4444);
        for (int i = 1; i < 8; i++) step();
        tests++; if (bus.br_ready !== 1'b0 || bus.timeout_err !== 1'b0) begin fails++; $display("FAIL tmo_early got rdy=%b tmo=%b want 0/0", bus.br_ready, bus.timeout_err); end
        step();
        tests++; if (bus.timeout_err !== 1'b1 || bus.br_ready !== 1'b1 || bus.redirect !== 1'b0) begin fails++; $display("FAIL tmo_fire got tmo=%b rdy=%b r=%b want 1/1/0", bus.timeout_err, bus.br_ready, bus.redirect); end
        tests++; if (bus.br_cnt !== 4'(exp_br) || bus.taken_cnt !== 4'(exp_tk)) begin fails++; $display("FAIL tmo_cnt got %0d/%0d want %0d/%0d", bus.br_cnt, bus.taken_cnt, exp_br, exp_tk); end
        $display("[TB] timeout transaction done");
    endtask

    task automatic test_flags_on_last();
        accept(3'b101, 16'h5555);
        for (int i = 1; i < 8; i++) step();
        bus.flags_valid = 1'b1; bus.ZF = 1'b0;
        step();
        idle_inputs();
        exp_br++; exp_tk++;
        tests++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 16'h5555) begin fails++; $display("FAIL last_redirect got r=%b pc=%h want 1/5555", bus.redirect, bus.redirect_pc); end
        tests++; if (bus.timeout_err !== 1'b1) begin fails++; $display("FAIL last_sticky got %b want 1", bus.timeout_err); end
        tests++; if (bus.br_cnt !== 4'(exp_br) || bus.taken_cnt !== 4'(exp_tk)) begin fails++; $display("FAIL last_cnt got %0d/%0d want %0d/%0d", bus.br_cnt, bus.taken_cnt, exp_br, exp_tk); end
        step(); step();
        tests++; if (bus.br_ready !== 1'b1 || bus.flush !== 1'b0) begin fails++; $display("FAIL last_idle got rdy=%b f=%b want 1/0", bus.br_ready, bus.flush); end
        $display("[TB] flags-on-last-cycle transaction done");
    endtask

    task automatic test_ext_flush();
        accept(3'b100, 16'h6666);
        bus.flags_valid = 1'b1; bus.ZF = 1'b1; bus.ext_flush = 1'b1;
        step();
        idle_inputs();
        tests++; if (bus.redirect !== 1'b0 || bus.flush !== 1'b0 || bus.br_ready !== 1'b1) begin fails++; $display("FAIL xflush got r=%b f=%b rdy=%b want 0/0/1", bus.redirect, bus.flush, bus.br_ready); end
        tests++; if (bus.br_cnt !== 4'(exp_br) || bus.taken_cnt !== 4'(exp_tk)) begin fails++; $display("FAIL xflush_cnt got %0d/%0d want %0d/%0d", bus.br_cnt, bus.taken_cnt, exp_br, exp_tk); end
        $display("[TB] ext_flush transaction done");
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 14; n++) begin
            accept(3'b100, 16'(16'h7000 + n));
            bus.flags_valid = 1'b1; bus.ZF = 1'b1;
            step();
            idle_inputs();
            if (exp_br < 15) exp_br++;
            if (exp_tk < 15) exp_tk++;
            tests++; if (bus.br_cnt !== 4'(exp_br) || bus.taken_cnt !== 4'(exp_tk)) begin fails++; $display("FAIL sat_cnt[%0d] got %0d/%0d want %0d/%0d", n, bus.br_cnt, bus.taken_cnt, exp_br, exp_tk); end
            step(); step();
        end
        tests++; if (bus.taken_cnt !== 4'hF || bus.br_cnt !== 4'hF) begin fails++; $display("FAIL sat_final got %h/%h want F/F", bus.br_cnt, bus.taken_cnt); end
        $display("[TB] saturation sequence done");
    endtask

    task automatic test_reset_mid_flush();
        accept(3'b111, 16'h8888);
        bus.flags_valid = 1'b1; bus.SF = 1'b0;
        step();
        idle_inputs();
        tests++; if (bus.flush !== 1'b1) begin fails++; $display("FAIL midrst_pre got f=%b want 1", bus.flush); end
        rst_n = 1'b0;
        step();
        tests++; if (bus.flush !== 1'b0 || bus.redirect !== 1'b0 || bus.br_ready !== 1'b1 || bus.redirect_pc !== 16'h0000) begin fails++; $display("FAIL midrst_out got f=%b r=%b rdy=%b pc=%h want 0/0/1/0000", bus.flush, bus.redirect, bus.br_ready, bus.redirect_pc); end
        tests++; if (bus.timeout_err !== 1'b0 || bus.br_cnt !== 4'd0 || bus.taken_cnt !== 4'd0) begin fails++; $display("FAIL midrst_stat got tmo=%b %0d/%0d want 0 0/0", bus.timeout_err, bus.br_cnt, bus.taken_cnt); end
        rst_n = 1'b1;
        step();
        tests++; if (bus.br_ready !== 1'b1 || bus.flush !== 1'b0) begin fails++; $display("FAIL midrst_post got rdy=%b f=%b want 1/0", bus.br_ready, bus.flush); end
        $display("[TB] reset mid-flush done");
    endtask

    initial begin
        test_reset();
        test_beqz_taken();
        test_bltz_not_taken();
        test_disabled_and_hold();
        test_timeout();
        test_flags_on_last();
        test_ext_flush();
        test_saturation();
        test_reset_mid_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
